// File: rtl/motor_axil_pkg.sv
// Shared definitions for the motor AXI4-Lite register block.
package motor_axil_pkg;

  // Byte offsets of the four registers; bits [3:2] form the register index
  localparam logic [3:0] REG_CTRL_OFF    = 4'h0;
  localparam logic [3:0] REG_PERIOD_OFF  = 4'h4;
  localparam logic [3:0] REG_DUTY_OFF    = 4'h8;
  localparam logic [3:0] REG_SCRATCH_OFF = 4'hC;

  localparam logic [1:0] IDX_CTRL    = REG_CTRL_OFF[3:2];
  localparam logic [1:0] IDX_PERIOD  = REG_PERIOD_OFF[3:2];
  localparam logic [1:0] IDX_DUTY    = REG_DUTY_OFF[3:2];
  localparam logic [1:0] IDX_SCRATCH = REG_SCRATCH_OFF[3:2];

  // CTRL register fields
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_DIR_BIT    = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  // Merge new data into an old word, one byte lane per strobe bit
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// Free-running PWM generator with period/duty shadowed at period boundaries.
module motor_pwm_gen
  import motor_axil_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [31:0] duty,
  output logic        pwm
);

  logic [31:0] cnt_reg;
  logic [31:0] period_sh_reg;
  logic [31:0] duty_sh_reg;
  logic        pwm_reg;

  // Counter, shadow reload and registered compare output
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_reg       <= '0;
      period_sh_reg <= '0;
      duty_sh_reg   <= '0;
      pwm_reg       <= 1'b0;
    end else if (!enable) begin
      // Disabled: idle low and track the programmed values continuously
      cnt_reg       <= '0;
      period_sh_reg <= period;
      duty_sh_reg   <= duty;
      pwm_reg       <= 1'b0;
    end else if (period_sh_reg == 32'd0) begin
      // Zero period parks the counter; keep reloading so a new period is seen
      cnt_reg       <= '0;
      period_sh_reg <= period;
      duty_sh_reg   <= duty;
      pwm_reg       <= 1'b0;
    end else begin
      // Output reflects the current count against the duty of the same period
      pwm_reg <= (cnt_reg < duty_sh_reg);
      if (cnt_reg == period_sh_reg - 32'd1) begin
        cnt_reg       <= '0;
        period_sh_reg <= period;
        duty_sh_reg   <= duty;
      end else begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/motor_axil_regs.sv
// AXI4-Lite responder holding CTRL/PERIOD/DUTY/SCRATCH and driving the PWM stage.
module motor_axil_regs
  import motor_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              motor_pwm,
  output logic                              motor_dir
);

  wr_state_t   wr_state_reg;
  logic        live_reg;
  logic        bvalid_reg;
  logic [1:0]  aw_idx_reg;
  logic [31:0] w_data_reg;
  logic [3:0]  w_strb_reg;
  logic        rvalid_reg;
  logic [31:0] rdata_reg;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] regs_q [4];

  // PROT and the byte-offset bits carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready only once out of reset; each channel accepts until captured
  assign S_AXI_AWREADY = live_reg && (wr_state_reg == WR_IDLE || wr_state_reg == WR_HAVE_W);
  assign S_AXI_WREADY  = live_reg && (wr_state_reg == WR_IDLE || wr_state_reg == WR_HAVE_AW);
  assign S_AXI_ARREADY = live_reg && !rvalid_reg;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Commit selects live channel values or the earlier-captured half
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = S_AXI_AWADDR[3:2];
    wr_data = S_AXI_WDATA;
    wr_strb = S_AXI_WSTRB;
    case (wr_state_reg)
      WR_IDLE:    wr_en = aw_hs && w_hs;
      WR_HAVE_AW: begin
        wr_en  = w_hs;
        wr_idx = aw_idx_reg;
      end
      WR_HAVE_W:  begin
        wr_en   = aw_hs;
        wr_data = w_data_reg;
        wr_strb = w_strb_reg;
      end
      default:    wr_en = 1'b0;
    endcase
  end

  // Write channel FSM: capture AW/W in any order, then hold B until accepted
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_state_reg <= WR_IDLE;
      live_reg     <= 1'b0;
      bvalid_reg   <= 1'b0;
      aw_idx_reg   <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
    end else begin
      live_reg <= 1'b1;
      case (wr_state_reg)
        WR_IDLE: begin
          if (wr_en) begin
            wr_state_reg <= WR_RESP;
            bvalid_reg   <= 1'b1;
          end else if (aw_hs) begin
            aw_idx_reg   <= S_AXI_AWADDR[3:2];
            wr_state_reg <= WR_HAVE_AW;
          end else if (w_hs) begin
            w_data_reg   <= S_AXI_WDATA;
            w_strb_reg   <= S_AXI_WSTRB;
            wr_state_reg <= WR_HAVE_W;
          end
        end
        WR_HAVE_AW, WR_HAVE_W: begin
          if (wr_en) begin
            wr_state_reg <= WR_RESP;
            bvalid_reg   <= 1'b1;
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            wr_state_reg <= WR_IDLE;
            bvalid_reg   <= 1'b0;
          end
        end
        default: wr_state_reg <= WR_IDLE;
      endcase
    end
  end

  // Register file: one word per index, byte-wise update on commit
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_reg
      logic [31:0] value_reg;
      always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
          value_reg <= '0;
        end else if (wr_en && wr_idx == 2'(gi)) begin
          value_reg <= apply_strb(value_reg, wr_data, wr_strb);
        end
      end
      assign regs_q[gi] = value_reg;
    end
  endgenerate

  // Read channel: register the addressed word, hold it until accepted
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= regs_q[S_AXI_ARADDR[3:2]];
    end else if (rvalid_reg && S_AXI_RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_reg;
  assign S_AXI_BRESP  = RESP_OKAY;
  assign S_AXI_RVALID = rvalid_reg;
  assign S_AXI_RDATA  = rdata_reg;
  assign S_AXI_RRESP  = RESP_OKAY;
  assign motor_dir    = regs_q[IDX_CTRL][CTRL_DIR_BIT];

  motor_pwm_gen u_pwm (
    .clk    (S_AXI_ACLK),
    .resetn (S_AXI_ARESETN),
    .enable (regs_q[IDX_CTRL][CTRL_ENABLE_BIT]),
    .period (regs_q[IDX_PERIOD]),
    .duty   (regs_q[IDX_DUTY]),
    .pwm    (motor_pwm)
  );

endmodule

// File: tb/tb_motor_axil_regs.sv
// Directed bench for motor_axil_regs with scoreboarded B/R responses.
module tb_motor_axil_regs;
  import motor_axil_pkg::*;

  logic        tb_ACLK = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        motor_pwm;
  logic        motor_dir;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [4];
  logic [31:0] rd_q [$];
  logic [1:0]  bresp_q [$];

  always #5 tb_ACLK = ~tb_ACLK;

  motor_axil_regs dut (
    .S_AXI_ACLK    (tb_ACLK),
    .S_AXI_ARESETN (aresetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .motor_pwm     (motor_pwm),
    .motor_dir     (motor_dir)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  // Wait for the B beat, pop the expected response and compare
  task automatic wait_b(input logic [3:0] addr);
    int n;
    logic [1:0] e;
    n = 0;
    bready = 1'b1;
    while (!bvalid && n < 20) begin
      @(negedge tb_ACLK);
      n++;
    end
    e = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b11;
    if (bvalid) begin
      check("bresp", 32'(bresp), 32'(e));
      $display("wr  addr=%h resp=%0d", addr, bresp);
      @(negedge tb_ACLK);
    end else begin
      check("b_timeout", 32'd0, 32'd1);
    end
  endtask

  // Full write with AW and W presented together; call at a negedge
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done, w_done, aw_now, w_now;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    bresp_q.push_back(RESP_OKAY);
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      @(negedge tb_ACLK);
      if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
      if (w_now)  begin wvalid  = 1'b0; w_done  = 1; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) check("aw_w_timeout", 32'd0, 32'd1);
    model_write(addr, data, strb);
    wait_b(addr);
  endtask

  // Read with the model value queued as the expectation; call at a negedge
  task automatic axi_read(input logic [3:0] addr);
    int n;
    logic [31:0] e;
    rd_q.push_back(model[addr[3:2]]);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge tb_ACLK);
      n++;
    end
    if (!arready) check("ar_timeout", 32'd0, 32'd1);
    @(negedge tb_ACLK);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge tb_ACLK);
      n++;
    end
    e = rd_q.pop_front();
    if (rvalid) begin
      check($sformatf("rdata@%h", addr), rdata, e);
      check("rresp", 32'(rresp), 32'(RESP_OKAY));
      $display("rd  addr=%h data=%h exp=%h", addr, rdata, e);
      @(negedge tb_ACLK);
    end else begin
      check("r_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic count_pwm(input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge tb_ACLK);
      if (motor_pwm) highs++;
    end
  endtask

  initial begin
    logic [19:0] pat, exp_pat;
    logic prev;
    int n, highs;
    bit found;

    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state
    repeat (3) @(negedge tb_ACLK);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_pwm", 32'(motor_pwm), 32'd0);
    check("rst_dir", 32'(motor_dir), 32'd0);
    aresetn = 1'b1;
    @(negedge tb_ACLK);
    check("post_rst_awready", 32'(awready), 32'd1);

    // 1) Write all four registers and read them back
    axi_write(4'h0, 32'h0101FFFF, 4'hF);
    axi_write(4'h4, 32'hABCD0001, 4'hF);
    axi_write(4'h8, 32'hDEAD0011, 4'hF);
    axi_write(4'hC, 32'hBEEF0011, 4'hF);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4));
    check("dir_from_ctrl", 32'(motor_dir), 32'd1);

    // 2) W three cycles ahead of AW, B back-pressured
    bready = 1'b0;
    wdata = 32'h5A5A1234; wstrb = 4'hF; wvalid = 1'b1;
    bresp_q.push_back(RESP_OKAY);
    check("t2_wready_before", 32'(wready), 32'd1);
    @(negedge tb_ACLK);
    wvalid = 1'b0;
    check("t2_wready_after", 32'(wready), 32'd0);
    check("t2_awready_waiting", 32'(awready), 32'd1);
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    awaddr = 4'hC; awvalid = 1'b1;
    check("t2_awready_before", 32'(awready), 32'd1);
    check("t2_bvalid_before", 32'(bvalid), 32'd0);
    @(negedge tb_ACLK);
    awvalid = 1'b0;
    check("t2_bvalid_1cyc", 32'(bvalid), 32'd1);
    model_write(4'hC, 32'h5A5A1234, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge tb_ACLK);
      check("t2_bvalid_hold", 32'(bvalid), 32'd1);
      check("t2_awready_hold", 32'(awready), 32'd0);
      check("t2_wready_hold", 32'(wready), 32'd0);
    end
    wait_b(4'hC);
    check("t2_bvalid_clear", 32'(bvalid), 32'd0);
    axi_read(4'hC);

    // 3) Partial strobe write
    axi_write(4'hC, 32'hFFFFFFFF, 4'hF);
    axi_write(4'hC, 32'h12345678, 4'b0101);
    axi_read(4'hC);
    check("t3_model_value", model[3], 32'hFF34FF78);

    // 4) PWM 3/10, then DUTY=7 mid-period
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'd10, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    prev = motor_pwm; found = 0; n = 0;
    while (!found && n < 40) begin
      @(negedge tb_ACLK);
      if (motor_pwm && !prev) found = 1;
      prev = motor_pwm;
      n++;
    end
    check("t4_pwm_rise_seen", 32'(found), 32'd1);
    pat = '0;
    pat[0] = motor_pwm;
    fork
      axi_write(4'h8, 32'd7, 4'hF);
      begin
        for (int i = 1; i < 20; i++) begin
          @(negedge tb_ACLK);
          pat[i] = motor_pwm;
        end
      end
    join
    for (int i = 0; i < 20; i++) exp_pat[i] = (i < 3) || (i >= 10 && i < 17);
    check("t4_pwm_pattern", 32'(pat), 32'(exp_pat));
    @(negedge tb_ACLK);
    count_pwm(10, highs);
    check("t4_duty7_steady", highs, 32'd7);

    // 5) Period zero, duty beyond period, enable cleared
    axi_write(4'h4, 32'd0, 4'hF);
    repeat (12) @(negedge tb_ACLK);
    count_pwm(20, highs);
    check("t5_period0_low", highs, 32'd0);
    axi_write(4'h8, 32'd20, 4'hF);
    axi_write(4'h4, 32'd10, 4'hF);
    repeat (3) @(negedge tb_ACLK);
    count_pwm(20, highs);
    check("t5_duty_ge_period_high", highs, 32'd20);
    axi_write(4'h0, 32'h2, 4'hF);
    check("t5_dir", 32'(motor_dir), 32'd1);
    check("t5_pwm_off", 32'(motor_pwm), 32'd0);

    // 6) Reset while AW captured and W pending
    awaddr = 4'h4; awvalid = 1'b1;
    check("t6_awready", 32'(awready), 32'd1);
    @(negedge tb_ACLK);
    awvalid = 1'b0;
    aresetn = 1'b0;
    @(negedge tb_ACLK);
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (5) @(negedge tb_ACLK);
    check("t6_no_bvalid", 32'(bvalid), 32'd0);
    check("t6_wready_idle", 32'(wready), 32'd1);
    check("t6_pwm", 32'(motor_pwm), 32'd0);
    check("t6_dir", 32'(motor_dir), 32'd0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4));
    check("t6_no_bvalid_late", 32'(bvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
